// File: rtl/aes_pkg.sv
// aes_pkg: shared helpers for the AES ShiftRows datapath.
//   nb_is_legal(nb)      - 1 when nb is a supported Rijndael column count (4, 6, 8)
//   row_shift(nb, r)     - cyclic shift applied to state row r
//   byte_msb(nb, r, c)   - bit index of the MSB of byte (row r, column c) in a
//                          column-major state vector of 32*nb bits
package aes_pkg;

    function automatic bit nb_is_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Rijndael with 8 columns shifts rows 2 and 3 one position further
    // than the 4/6 column variants.
    function automatic int row_shift(input int nb, input int r);
        return ((nb == 8) && (r >= 2)) ? r + 1 : r;
    endfunction

    // Byte n = 4*c + r sits at bits [W-1-8n -: 8].
    function automatic int byte_msb(input int nb, input int r, input int c);
        return 32 * nb - 1 - 8 * (4 * c + r);
    endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// aes_shift_rows_perm: combinational ShiftRows / InvShiftRows byte permutation.
//   src_data [32*NB-1:0] - input state, column-major bytes
//   inv                  - 0: ShiftRows, 1: InvShiftRows
//   dst_data [32*NB-1:0] - permuted state, same byte layout
module aes_shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] src_data,
    input  logic             inv,
    output logic [32*NB-1:0] dst_data
);

    // Each output byte is a 2:1 mux between its forward and inverse source
    // byte; both source positions are elaboration-time constants.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int FWD_COL = (c + row_shift(NB, r)) % NB;
            localparam int INV_COL = (c - row_shift(NB, r) + NB) % NB;
            localparam int DST_MSB = byte_msb(NB, r, c);
            localparam int FWD_MSB = byte_msb(NB, r, FWD_COL);
            localparam int INV_MSB = byte_msb(NB, r, INV_COL);

            assign dst_data[DST_MSB -: 8] = inv ? src_data[INV_MSB -: 8]
                                                : src_data[FWD_MSB -: 8];
        end
    end

endmodule

// File: rtl/aes_shift_rows_stage.sv
// aes_shift_rows_stage: one-cycle ShiftRows/InvShiftRows pipeline stage with a
// valid/ready handshake on both sides and a skid register so that in_ready is
// registered while 1 block/cycle throughput is sustained.
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   - upstream handshake (in_ready = not skid_full)
//   in_data, in_inv       - state (32*NB bits, column-major) and mode per block
//   in_tag                - sideband, passed through with its block
//   out_valid / out_ready - downstream handshake
//   out_data, out_tag     - permuted state and its tag
//   blk_count             - wrapping count of output transfers
module aes_shift_rows_stage
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic [15:0]        blk_count
);

    localparam int W = 32 * NB;

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $error("aes_shift_rows_stage: NB must be 4, 6 or 8");
    end

    if ((TAG_W < 1) || (TAG_W > 16)) begin : g_bad_tag_w
        $error("aes_shift_rows_stage: TAG_W must be in 1..16");
    end

    // Stage 0: permute on the input side so the mode never has to be stored.
    logic [W-1:0] perm_data_p0;

    aes_shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .src_data (in_data),
        .inv      (in_inv),
        .dst_data (perm_data_p0)
    );

    // Stage 1: output register plus skid register.
    logic [W-1:0]     out_data_p1;
    logic [TAG_W-1:0] out_tag_p1;
    logic             vld_p1;
    logic [W-1:0]     skid_data_p1;
    logic [TAG_W-1:0] skid_tag_p1;
    logic             skid_full;
    logic [15:0]      blk_count_q;

    logic in_xfer;
    logic out_xfer;

    assign in_ready = ~skid_full;
    assign in_xfer  = in_valid & ~skid_full;
    assign out_xfer = vld_p1 & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_p1  <= '0;
            out_tag_p1   <= '0;
            vld_p1       <= 1'b0;
            skid_data_p1 <= '0;
            skid_tag_p1  <= '0;
            skid_full    <= 1'b0;
            blk_count_q  <= '0;
        end else begin
            if (out_xfer) begin
                blk_count_q <= blk_count_q + 16'd1;
            end

            if (skid_full) begin
                // in_ready is low here, so only the skid can refill the output.
                if (out_ready) begin
                    out_data_p1 <= skid_data_p1;
                    out_tag_p1  <= skid_tag_p1;
                    vld_p1      <= 1'b1;
                    skid_full   <= 1'b0;
                end
            end else if (in_xfer) begin
                if (!vld_p1 || out_ready) begin
                    out_data_p1 <= perm_data_p0;
                    out_tag_p1  <= in_tag;
                    vld_p1      <= 1'b1;
                end else begin
                    skid_data_p1 <= perm_data_p0;
                    skid_tag_p1  <= in_tag;
                    skid_full    <= 1'b1;
                end
            end else if (out_xfer) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = out_data_p1;
    assign out_tag   = out_tag_p1;
    assign blk_count = blk_count_q;

endmodule
